// File: rtl/dmem_mmio_pkg.sv
// rtl/dmem_mmio_pkg.sv - shared constants, register map and decode helpers for the dmem MMIO responder
// Contents: bus widths, MMIO region base, register offsets, TX FIFO geometry,
//           STATUS bit positions, region/register decode functions.
package dmem_mmio_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  // Everything at or above this word address is MMIO; below it is data RAM.
  localparam logic [ADDR_W-1:0] MMIO_BASE = 12'hF00;

  // Register offsets relative to MMIO_BASE.
  localparam logic [ADDR_W-1:0] OFF_DEBUG   = 12'h000;
  localparam logic [ADDR_W-1:0] OFF_CYCLE   = 12'h001;
  localparam logic [ADDR_W-1:0] OFF_TX_DATA = 12'h002;
  localparam logic [ADDR_W-1:0] OFF_STATUS  = 12'h003;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W = 2;
  localparam int FIFO_CNT_W = 3;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_CNT_LSB   = 3;

  typedef enum logic [2:0] {
    MMIO_NONE,
    MMIO_DEBUG,
    MMIO_CYCLE,
    MMIO_TX_DATA,
    MMIO_STATUS
  } mmio_reg_e;

  function automatic logic in_mmio(input logic [ADDR_W-1:0] addr);
    return addr >= MMIO_BASE;
  endfunction

  // Unmapped MMIO offsets decode to MMIO_NONE: they read 0 and drop writes.
  function automatic mmio_reg_e decode_mmio(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    mmio_reg_e         sel;
    off = addr - MMIO_BASE;
    sel = MMIO_NONE;
    if (in_mmio(addr)) begin
      case (off)
        OFF_DEBUG:   sel = MMIO_DEBUG;
        OFF_CYCLE:   sel = MMIO_CYCLE;
        OFF_TX_DATA: sel = MMIO_TX_DATA;
        OFF_STATUS:  sel = MMIO_STATUS;
        default:     sel = MMIO_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// rtl/dmem_mmio_responder_if.sv - processor, data-RAM and TX stream signals of the dmem MMIO responder
// Processor side: address_dmem, data, wren (to responder), q_dmem (from responder).
// RAM side:       ram_address, ram_data, ram_wren (from responder), ram_q (to responder).
// TX stream:      tx_data, tx_valid (from responder), tx_ready (to responder).
// Modports: slave = responder view, master = processor/RAM/sink view.
interface dmem_mmio_responder_if;
  import dmem_mmio_pkg::*;

  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic [DATA_W-1:0] q_dmem;

  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport slave (
    input  address_dmem, data, wren, ram_q, tx_ready,
    output q_dmem, ram_address, ram_data, ram_wren, tx_data, tx_valid
  );

  modport master (
    output address_dmem, data, wren, ram_q, tx_ready,
    input  q_dmem, ram_address, ram_data, ram_wren, tx_data, tx_valid
  );

endinterface

// File: rtl/dmem_mmio_responder_tx_fifo.sv
// rtl/dmem_mmio_responder_tx_fifo.sv - 4 x 32 synchronous FIFO feeding the outbound word stream
// Ports: clock, reset (sync, active-low), push/push_data (write side),
//        pop/head (read side, head is the oldest entry), full, empty, count.
module tx_fifo
  import dmem_mmio_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  output logic [DATA_W-1:0]     head,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [DATA_W-1:0]     mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr;
  logic [FIFO_PTR_W-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full  = (count == FIFO_CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);

  // Storage is not reset; only pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// rtl/dmem_mmio_responder.sv - splits processor data accesses between data RAM and a small MMIO register block
// Ports: clock, reset (sync, active-low), bus (slave modport: processor, RAM and
//        TX stream signals), global_debug_out (current DEBUG register value).
module dmem_mmio_responder
  import dmem_mmio_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  dmem_mmio_responder_if.slave bus,
  output logic [DATA_W-1:0]    global_debug_out
);

  logic                  is_mmio;
  mmio_reg_e             sel;
  logic [DATA_W-1:0]     debug_q;
  logic [DATA_W-1:0]     cycle_q;
  logic                  overflow_q;
  logic [DATA_W-1:0]     status_word;
  logic [DATA_W-1:0]     mmio_rdata;

  logic                  wr_debug;
  logic                  wr_cycle;
  logic                  wr_tx;
  logic                  wr_status;
  logic                  ovf_set;
  logic                  ovf_clr;

  logic                  fifo_pop;
  logic [DATA_W-1:0]     fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;

  assign is_mmio = in_mmio(bus.address_dmem);
  assign sel     = decode_mmio(bus.address_dmem);

  // RAM path is purely combinational and independent of reset; the processor
  // gates its own stores during reset.
  assign bus.ram_address = bus.address_dmem;
  assign bus.ram_data    = bus.data;
  assign bus.ram_wren    = bus.wren & ~is_mmio;

  assign wr_debug  = bus.wren & (sel == MMIO_DEBUG);
  assign wr_cycle  = bus.wren & (sel == MMIO_CYCLE);
  assign wr_tx     = bus.wren & (sel == MMIO_TX_DATA);
  assign wr_status = bus.wren & (sel == MMIO_STATUS);

  assign fifo_pop = bus.tx_ready & ~fifo_empty;
  // A word is dropped only if the FIFO is full and no slot frees on this edge.
  assign ovf_set  = wr_tx & fifo_full & ~fifo_pop;
  assign ovf_clr  = wr_status & bus.data[STATUS_OVF_BIT];

  tx_fifo u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (wr_tx),
    .push_data (bus.data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      debug_q    <= '0;
      cycle_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_debug) begin
        debug_q <= bus.data;
      end
      // A write restarts the counter from zero, overriding this cycle's increment.
      cycle_q <= wr_cycle ? '0 : cycle_q + 1'b1;
      // Set beats clear when both land on the same edge.
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_comb begin
    status_word                                   = '0;
    status_word[STATUS_EMPTY_BIT]                 = fifo_empty;
    status_word[STATUS_FULL_BIT]                  = fifo_full;
    status_word[STATUS_OVF_BIT]                   = overflow_q;
    status_word[STATUS_CNT_LSB +: FIFO_CNT_W]     = fifo_count;
  end

  // TX_DATA is write-only and reads back as zero along with unmapped offsets.
  always_comb begin
    mmio_rdata = '0;
    case (sel)
      MMIO_DEBUG:  mmio_rdata = debug_q;
      MMIO_CYCLE:  mmio_rdata = cycle_q;
      MMIO_STATUS: mmio_rdata = status_word;
      default:     mmio_rdata = '0;
    endcase
  end

  assign bus.q_dmem       = is_mmio ? mmio_rdata : bus.ram_q;
  assign bus.tx_valid     = ~fifo_empty;
  assign bus.tx_data      = fifo_head;
  assign global_debug_out = debug_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb/tb_dmem_mmio_responder.sv - self-checking bench for dmem_mmio_responder
module tb_dmem_mmio_responder;
  import dmem_mmio_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] global_debug_out;

  dmem_mmio_responder_if bus();

  dmem_mmio_responder dut (
    .clock            (clock),
    .reset            (reset),
    .bus              (bus),
    .global_debug_out (global_debug_out)
  );

  always #5 clock = ~clock;

  // Data RAM clocked on the falling edge, read-old-data on collision.
  logic [31:0] ram_mem [4096];
  int          ram_wren_pulses = 0;
  always @(negedge clock) begin
    if (bus.ram_wren) begin
      ram_mem[bus.ram_address] <= bus.ram_data;
      ram_wren_pulses <= ram_wren_pulses + 1;
    end
    bus.ram_q <= ram_mem[bus.ram_address];
  end

  // Reference model state.
  logic [31:0] m_ram [4096];
  logic [31:0] m_debug;
  logic [31:0] m_cycle;
  logic        m_ovf;
  logic [31:0] m_fifo [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic drive(input logic [11:0] a, input logic [31:0] d, input logic w, input logic rdy);
    bus.address_dmem = a;
    bus.data         = d;
    bus.wren         = w;
    bus.tx_ready     = rdy;
  endtask

  task automatic model_step();
    bit pop, push_req, clr, was_full;
    if (bus.wren && bus.address_dmem < 12'hF00) m_ram[bus.address_dmem] = bus.data;
    if (!reset) begin
      m_debug = 0;
      m_cycle = 0;
      m_ovf   = 0;
      m_fifo.delete();
    end else begin
      was_full = (m_fifo.size() == 4);
      pop      = (m_fifo.size() != 0) && bus.tx_ready;
      push_req = bus.wren && bus.address_dmem == 12'hF02;
      clr      = bus.wren && bus.address_dmem == 12'hF03 && bus.data[2];
      if (pop) void'(m_fifo.pop_front());
      if (push_req) begin
        if (!was_full || pop) m_fifo.push_back(bus.data);
        else m_ovf = 1;
      end
      if (clr && !(push_req && was_full && !pop)) m_ovf = 0;
      if (bus.wren && bus.address_dmem == 12'hF00) m_debug = bus.data;
      if (bus.wren && bus.address_dmem == 12'hF01) m_cycle = 0;
      else m_cycle = m_cycle + 1;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    int sz;
    sz = m_fifo.size();
    if (a < 12'hF00) return m_ram[a];
    if (a == 12'hF00) return m_debug;
    if (a == 12'hF01) return m_cycle;
    if (a == 12'hF03) return (sz * 8) + (m_ovf ? 4 : 0) + ((sz == 4) ? 2 : 0) + ((sz == 0) ? 1 : 0);
    return 0;
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    drive(12'hF03, 0, 0, 0);
    reset = 0;
    tick();
    reset = 1;
    sample();
    n_checks++; if (bus.tx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_tx_valid: got %b expected 0", bus.tx_valid); end
    n_checks++; if (global_debug_out !== 32'h0) begin n_errors++; $display("FAIL reset_debug: got %h expected 0", global_debug_out); end
    n_checks++; if (bus.q_dmem !== 32'h1) begin n_errors++; $display("FAIL reset_status: got %h expected 00000001", bus.q_dmem); end
    bus.address_dmem = 12'hF01;
    #1;
    n_checks++; if (bus.q_dmem !== 32'h0) begin n_errors++; $display("FAIL reset_cycle0: got %h expected 0", bus.q_dmem); end
    tick();
    sample();
    n_checks++; if (bus.q_dmem !== 32'h1) begin n_errors++; $display("FAIL reset_cycle1: got %h expected 1", bus.q_dmem); end
    tick();
  endtask

  task automatic test_ram();
    int p0;
    p0 = ram_wren_pulses;
    drive(12'h010, 32'h12345678, 1, 0);
    sample();
    n_checks++; if (bus.ram_wren !== 1'b1) begin n_errors++; $display("FAIL ram_store_wren: got %b expected 1", bus.ram_wren); end
    tick();
    drive(12'h010, 0, 0, 0);
    sample();
    n_checks++; if (bus.q_dmem !== 32'h12345678) begin n_errors++; $display("FAIL ram_load: got %h expected 12345678", bus.q_dmem); end
    n_checks++; if (ram_wren_pulses - p0 !== 1) begin n_errors++; $display("FAIL ram_wren_pulses: got %0d expected 1", ram_wren_pulses - p0); end
    tick();
    drive(12'hF00, 32'hA5A5A5A5, 1, 0);
    sample();
    n_checks++; if (bus.ram_wren !== 1'b0) begin n_errors++; $display("FAIL mmio_store_wren: got %b expected 0", bus.ram_wren); end
    tick();
  endtask

  task automatic test_debug();
    drive(12'hF00, 32'hDEADBEEF, 1, 0);
    sample();
    tick();
    drive(12'hF00, 0, 0, 0);
    sample();
    n_checks++; if (global_debug_out !== 32'hDEADBEEF) begin n_errors++; $display("FAIL debug_out: got %h expected deadbeef", global_debug_out); end
    n_checks++; if (bus.q_dmem !== 32'hDEADBEEF) begin n_errors++; $display("FAIL debug_read: got %h expected deadbeef", bus.q_dmem); end
    tick();
  endtask

  task automatic test_cycle();
    drive(12'h000, 0, 0, 0);
    reset = 0;
    tick();
    reset = 1;
    repeat (10) tick();
    drive(12'hF01, 0, 0, 0);
    sample();
    n_checks++; if (bus.q_dmem !== 32'd10) begin n_errors++; $display("FAIL cycle_after_10: got %0d expected 10", bus.q_dmem); end
    drive(12'hF01, 32'h55, 1, 0);
    tick();
    drive(12'hF01, 0, 0, 0);
    sample();
    n_checks++; if (bus.q_dmem !== 32'd0) begin n_errors++; $display("FAIL cycle_write0: got %0d expected 0", bus.q_dmem); end
    tick();
    sample();
    n_checks++; if (bus.q_dmem !== 32'd1) begin n_errors++; $display("FAIL cycle_write1: got %0d expected 1", bus.q_dmem); end
    tick();
  endtask

  task automatic test_fifo_overflow();
    drive(12'h000, 0, 0, 0);
    reset = 0;
    tick();
    reset = 1;
    drive(12'hF02, 1, 1, 0);
    sample();
    n_checks++; if (bus.tx_valid !== 1'b0) begin n_errors++; $display("FAIL no_bypass: got %b expected 0", bus.tx_valid); end
    tick();
    drive(12'hF02, 2, 1, 0);
    sample();
    n_checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 32'd1) begin n_errors++; $display("FAIL first_valid: got %b/%h expected 1/00000001", bus.tx_valid, bus.tx_data); end
    tick();
    for (int v = 3; v <= 4; v++) begin
      drive(12'hF02, v, 1, 0);
      tick();
    end
    drive(12'hF03, 0, 0, 0);
    sample();
    n_checks++; if (bus.q_dmem !== 32'h22) begin n_errors++; $display("FAIL status_full: got %h expected 00000022", bus.q_dmem); end
    tick();
    drive(12'hF02, 5, 1, 0);
    tick();
    drive(12'hF03, 0, 0, 0);
    sample();
    n_checks++; if (bus.q_dmem !== 32'h26) begin n_errors++; $display("FAIL status_ovf: got %h expected 00000026", bus.q_dmem); end
    tick();
    for (int i = 1; i <= 4; i++) begin
      drive(12'h000, 0, 0, 1);
      sample();
      n_checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 32'(i)) begin n_errors++; $display("FAIL drain_%0d: got %b/%h expected 1/%h", i, bus.tx_valid, bus.tx_data, 32'(i)); end
      tick();
    end
    drive(12'hF03, 0, 0, 0);
    sample();
    n_checks++; if (bus.q_dmem !== 32'h05) begin n_errors++; $display("FAIL status_drained: got %h expected 00000005", bus.q_dmem); end
    tick();
    drive(12'hF03, 32'hFFFF_FFFF, 1, 0);
    tick();
    drive(12'hF03, 0, 0, 0);
    sample();
    n_checks++; if (bus.q_dmem !== 32'h01) begin n_errors++; $display("FAIL status_ovf_clear: got %h expected 00000001", bus.q_dmem); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_words [4];
    exp_words = '{32'd6, 32'd7, 32'd8, 32'd9};
    for (int v = 5; v <= 8; v++) begin
      drive(12'hF02, v, 1, 0);
      tick();
    end
    drive(12'hF02, 9, 1, 1);
    sample();
    n_checks++; if (bus.tx_data !== 32'd5) begin n_errors++; $display("FAIL b2b_head: got %h expected 00000005", bus.tx_data); end
    tick();
    drive(12'hF03, 0, 0, 0);
    sample();
    n_checks++; if (bus.q_dmem !== 32'h22) begin n_errors++; $display("FAIL b2b_status: got %h expected 00000022", bus.q_dmem); end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(12'h000, 0, 0, 1);
      sample();
      n_checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp_words[i]) begin n_errors++; $display("FAIL b2b_out_%0d: got %b/%h expected 1/%h", i, bus.tx_valid, bus.tx_data, exp_words[i]); end
      tick();
    end
    drive(12'hF03, 0, 0, 0);
    sample();
    n_checks++; if (bus.q_dmem !== 32'h01) begin n_errors++; $display("FAIL b2b_empty: got %h expected 00000001", bus.q_dmem); end
    tick();
  endtask

  task automatic test_reset_traffic();
    drive(12'hF00, 32'hCAFEF00D, 1, 0);
    tick();
    for (int v = 1; v <= 3; v++) begin
      drive(12'hF02, 32'h100 + v, 1, 0);
      tick();
    end
    drive(12'hF03, 0, 0, 0);
    sample();
    n_checks++; if (bus.q_dmem !== 32'h18) begin n_errors++; $display("FAIL three_words: got %h expected 00000018", bus.q_dmem); end
    reset = 0;
    drive(12'hF00, 32'h11111111, 1, 0);
    tick();
    reset = 1;
    drive(12'hF03, 0, 0, 0);
    sample();
    n_checks++; if (bus.tx_valid !== 1'b0) begin n_errors++; $display("FAIL rst_traffic_valid: got %b expected 0", bus.tx_valid); end
    n_checks++; if (bus.q_dmem !== 32'h01) begin n_errors++; $display("FAIL rst_traffic_status: got %h expected 00000001", bus.q_dmem); end
    n_checks++; if (global_debug_out !== 32'h0) begin n_errors++; $display("FAIL rst_traffic_debug: got %h expected 0", global_debug_out); end
    tick();
  endtask

  task automatic test_random();
    logic [11:0] a;
    logic [31:0] d;
    logic        w, rdy;
    int          cat;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) != 0);
      cat   = $urandom_range(0, 3);
      if (cat == 0)      a = 12'($urandom_range(0, 15));
      else if (cat == 3) a = 12'($urandom_range(12'hF04, 12'hFFF));
      else               a = 12'hF00 + 12'($urandom_range(0, 3));
      d   = $urandom();
      w   = 1'($urandom_range(0, 1));
      rdy = 1'($urandom_range(0, 1));
      drive(a, d, w, rdy);
      sample();
      n_checks++; if (bus.q_dmem !== model_read(a)) begin n_errors++; $display("FAIL rand_q_%0d addr %h: got %h expected %h", i, a, bus.q_dmem, model_read(a)); end
      n_checks++; if (bus.tx_valid !== (m_fifo.size() != 0)) begin n_errors++; $display("FAIL rand_valid_%0d: got %b expected %b", i, bus.tx_valid, m_fifo.size() != 0); end
      if (m_fifo.size() != 0) begin
        n_checks++; if (bus.tx_data !== m_fifo[0]) begin n_errors++; $display("FAIL rand_txdata_%0d: got %h expected %h", i, bus.tx_data, m_fifo[0]); end
      end
      n_checks++; if (global_debug_out !== m_debug) begin n_errors++; $display("FAIL rand_debug_%0d: got %h expected %h", i, global_debug_out, m_debug); end
      n_checks++; if (bus.ram_wren !== (w && a < 12'hF00)) begin n_errors++; $display("FAIL rand_ram_wren_%0d: got %b expected %b", i, bus.ram_wren, w && a < 12'hF00); end
      tick();
    end
    reset = 1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram_mem[i] = 0;
      m_ram[i]   = 0;
    end
    reset = 0;
    drive(12'h000, 0, 0, 0);
    tick();
    tick();
    reset = 1;
    test_reset();
    test_ram();
    test_debug();
    test_cycle();
    test_fifo_overflow();
    test_back_to_back();
    test_reset_traffic();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within 500000 time units");
    $fatal(1, "timeout");
  end

endmodule
